// File: rtl/pkt_tx_assembler.sv
// rtl/pkt_tx_assembler.sv - sensor-node packet assembler: latches a request, checks energy, streams HB/CHE/data words
module pkt_tx_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  pktType,
  input  logic [15:0] myNodeID,
  input  logic [15:0] hopsFromSink,
  input  logic [15:0] myQValue,
  input  logic [15:0] destinationID,
  input  logic [15:0] payload,
  input  logic [15:0] energy,
  input  logic [15:0] e_threshold,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] energy_out
);

  localparam logic [15:0] HOP1_TX = 16'h0005;
  localparam logic [15:0] HOP4_TX = 16'h001B;
  localparam logic [2:0]  PT_HB   = 3'b000;
  localparam logic [2:0]  PT_CHE  = 3'b001;
  localparam logic [2:0]  PT_DATA = 3'b101;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, FINISH} state_t;

  state_t      state, state_nxt;
  logic [2:0]  type_q;
  logic [15:0] node_q, hops_q, qval_q, dest_q, payload_q, energy_q, thr_q;
  logic [7:0]  seq;
  logic [2:0]  word_idx;

  logic [15:0] cost, hops_inc, header, word;
  logic [2:0]  last_idx;
  logic        supported, reject;

  // Threshold travels with the request but the transmit path does not consume it.
  logic unused_thr;
  assign unused_thr = ^thr_q;

  always_comb begin
    cost      = (hops_q <= 16'd1) ? HOP1_TX : HOP4_TX;
    hops_inc  = (hops_q == 16'hFFFF) ? 16'hFFFF : hops_q + 16'd1;
    header    = {type_q, 5'b0, seq};
    supported = 1'b1;
    last_idx  = 3'd0;
    word      = header;
    case (type_q)
      PT_HB: begin
        last_idx = 3'd3;
        case (word_idx)
          3'd0:    word = header;
          3'd1:    word = node_q;
          3'd2:    word = hops_inc;
          default: word = energy_q;
        endcase
      end
      PT_CHE: begin
        last_idx = 3'd2;
        case (word_idx)
          3'd0:    word = header;
          3'd1:    word = node_q;
          default: word = dest_q;
        endcase
      end
      PT_DATA: begin
        last_idx = 3'd4;
        case (word_idx)
          3'd0:    word = header;
          3'd1:    word = node_q;
          3'd2:    word = dest_q;
          3'd3:    word = qval_q;
          default: word = payload_q;
        endcase
      end
      default: supported = 1'b0;
    endcase
    reject = !supported || (energy_q < cost);
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    tx_valid  = (state == SEND);
    tx_last   = (state == SEND) && (word_idx == last_idx);
    tx_data   = (state == SEND) ? word : 16'h0000;
    done      = (state == FINISH);
    err       = (state == LOAD) && reject;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = reject ? IDLE : SEND;
      SEND:    if (tx_ready && tx_last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      seq        <= 8'h00;
      energy_out <= 16'h0000;
      word_idx   <= 3'd0;
      type_q     <= 3'd0;
      node_q     <= 16'h0000;
      hops_q     <= 16'h0000;
      qval_q     <= 16'h0000;
      dest_q     <= 16'h0000;
      payload_q  <= 16'h0000;
      energy_q   <= 16'h0000;
      thr_q      <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        type_q    <= pktType;
        node_q    <= myNodeID;
        hops_q    <= hopsFromSink;
        qval_q    <= myQValue;
        dest_q    <= destinationID;
        payload_q <= payload;
        energy_q  <= energy;
        thr_q     <= e_threshold;
      end
      if (state == LOAD) word_idx <= 3'd0;
      if (state == SEND && tx_ready) begin
        if (tx_last) begin
          energy_out <= energy_q - cost;
          seq        <= seq + 8'd1;
        end else begin
          word_idx <= word_idx + 3'd1;
        end
      end
    end
  end

endmodule
